// File: rtl/instr_control_unit.sv
// Control sequencer for the 16-bit accumulator datapath.
// Decodes Mano-style instruction words, fetches operands over a req/ack port and sequences register-reference micro-ops.
module instr_control_unit #(
    parameter int A      = 16,
    parameter int ADDR_W = A - 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              ir_valid,
    output logic              ir_ready,
    input  logic [A-1:0]      ir,
    input  logic [A-1:0]      ac,
    input  logic              E,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [A-1:0]      mem_wdata,
    input  logic              mem_ack,
    input  logic [A-1:0]      mem_rdata,
    output logic [3:0]        ALUOP,
    output logic [A-1:0]      dr,
    output logic              ac_load,
    output logic              skip,
    output logic              halt,
    output logic              illegal
);

    localparam logic [3:0] OP_AND = 4'b0000, OP_ADD = 4'b0001, OP_CLA = 4'b0010,
                           OP_CMA = 4'b0011, OP_CIR = 4'b0100, OP_CIL = 4'b0101,
                           OP_INC = 4'b0110, OP_CLE = 4'b0111, OP_CME = 4'b1000,
                           OP_SPA = 4'b1001, OP_SNA = 4'b1010, OP_SZA = 4'b1011,
                           OP_SZE = 4'b1100, OP_LDA = 4'b1101;

    typedef enum logic [2:0] {
        S_IDLE, S_INDIR, S_OPERAND, S_EXEC, S_STORE, S_RREF, S_HALTED
    } state_t;

    state_t            r_state;
    logic [1:0]        r_op;
    logic [ADDR_W-1:0] r_ea;
    logic [11:0]       r_mask;
    logic [A-1:0]      r_dr;
    logic              r_illegal;

    logic [3:0]  w_idx;
    logic [11:0] w_mask_next;
    logic [3:0]  w_rr_op;
    logic        w_rr_load;
    logic        w_rr_skip;
    logic [2:0]  w_opc;

    assign w_opc = ir[14:12];

    // Highest set mask bit wins; later loop iterations override lower ones.
    always_comb begin
        w_idx = 4'd0;
        for (int i = 0; i < 12; i++) begin
            if (r_mask[i]) w_idx = i[3:0];
        end
        w_mask_next = r_mask & ~(12'b1 << w_idx);
    end

    always_comb begin
        w_rr_op   = OP_LDA;
        w_rr_load = 1'b0;
        w_rr_skip = 1'b0;
        case (w_idx)
            4'd11: begin w_rr_op = OP_CLA; w_rr_load = 1'b1; end
            4'd10: w_rr_op = OP_CLE;
            4'd9:  begin w_rr_op = OP_CMA; w_rr_load = 1'b1; end
            4'd8:  w_rr_op = OP_CME;
            4'd7:  begin w_rr_op = OP_CIR; w_rr_load = 1'b1; end
            4'd6:  begin w_rr_op = OP_CIL; w_rr_load = 1'b1; end
            4'd5:  begin w_rr_op = OP_INC; w_rr_load = 1'b1; end
            4'd4:  begin w_rr_op = OP_SPA; w_rr_skip = ~ac[A-1]; end
            4'd3:  begin w_rr_op = OP_SNA; w_rr_skip = ac[A-1]; end
            4'd2:  begin w_rr_op = OP_SZA; w_rr_skip = (ac == '0); end
            4'd1:  begin w_rr_op = OP_SZE; w_rr_skip = ~E; end
            default: w_rr_op = OP_LDA;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state   <= S_IDLE;
            r_op      <= 2'b00;
            r_ea      <= '0;
            r_mask    <= '0;
            r_dr      <= '0;
            r_illegal <= 1'b0;
        end else begin
            r_illegal <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (ir_valid) begin
                        if (w_opc == 3'b111 && !ir[A-1]) begin
                            r_mask <= ir[11:0];
                            if (|ir[11:0]) r_state <= S_RREF;
                        end else if (!w_opc[2]) begin
                            r_op <= ir[13:12];
                            r_ea <= ir[ADDR_W-1:0];
                            if (ir[A-1])              r_state <= S_INDIR;
                            else if (ir[13:12] == 2'b11) r_state <= S_STORE;
                            else                      r_state <= S_OPERAND;
                        end else begin
                            r_illegal <= 1'b1;
                        end
                    end
                end
                S_INDIR: begin
                    if (mem_ack) begin
                        r_ea    <= mem_rdata[ADDR_W-1:0];
                        r_state <= (r_op == 2'b11) ? S_STORE : S_OPERAND;
                    end
                end
                S_OPERAND: begin
                    if (mem_ack) begin
                        r_dr    <= mem_rdata;
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC:  r_state <= S_IDLE;
                S_STORE: if (mem_ack) r_state <= S_IDLE;
                S_RREF: begin
                    if (w_idx == 4'd0) begin
                        r_mask  <= '0;
                        r_state <= S_HALTED;
                    end else begin
                        r_mask <= w_mask_next;
                        if (w_mask_next == '0) r_state <= S_IDLE;
                    end
                end
                S_HALTED: r_state <= S_HALTED;
                default:  r_state <= S_IDLE;
            endcase
        end
    end

    // ALU codes that update E only ever appear in the cycle that executes them.
    always_comb begin
        ALUOP   = OP_LDA;
        ac_load = 1'b0;
        skip    = 1'b0;
        case (r_state)
            S_EXEC: begin
                ac_load = 1'b1;
                case (r_op)
                    2'b00:   ALUOP = OP_AND;
                    2'b01:   ALUOP = OP_ADD;
                    default: ALUOP = OP_LDA;
                endcase
            end
            S_RREF: begin
                ALUOP   = w_rr_op;
                ac_load = w_rr_load;
                skip    = w_rr_skip;
            end
            default: ;
        endcase
    end

    assign ir_ready  = (r_state == S_IDLE);
    assign mem_req   = (r_state == S_INDIR) || (r_state == S_OPERAND) || (r_state == S_STORE);
    assign mem_we    = (r_state == S_STORE);
    assign mem_addr  = mem_req ? r_ea : '0;
    assign mem_wdata = ac;
    assign dr        = r_dr;
    assign halt      = (r_state == S_HALTED);
    assign illegal   = r_illegal;

endmodule

// File: tb/tb_instr_control_unit.sv
// Directed bench for instr_control_unit: a table of single-bit register-reference
// instructions plus hand-written sequences for memory, skip, halt and reset cases.
module tb_instr_control_unit;

    logic        CLK, RST, ir_valid, ir_ready, E;
    logic [15:0] ir, ac, mem_wdata, mem_rdata, dr;
    logic        mem_req, mem_we, mem_ack, ac_load, skip, halt, illegal;
    logic [11:0] mem_addr;
    logic [3:0]  ALUOP;

    int checks = 0;
    int errors = 0;

    instr_control_unit #(.A(16), .ADDR_W(12)) dut (
        .CLK(CLK), .RST(RST), .ir_valid(ir_valid), .ir_ready(ir_ready), .ir(ir),
        .ac(ac), .E(E), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .ALUOP(ALUOP), .dr(dr), .ac_load(ac_load), .skip(skip), .halt(halt),
        .illegal(illegal)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [15:0] ir;
        logic [15:0] ac;
        logic        e;
        logic [3:0]  aluop;
        logic        load;
        logic        skp;
    } vec_t;

    vec_t vecs [13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic issue(input logic [15:0] w);
        @(posedge CLK);
        #1 ir = w; ir_valid = 1'b1;
        @(posedge CLK);
        #1 ir_valid = 1'b0; ir = 16'h0;
    endtask

    // Called at a negedge: acks the current request on the coming posedge.
    task automatic ack_now(input logic [15:0] v);
        mem_ack = 1'b1; mem_rdata = v;
        @(posedge CLK);
        #1 mem_ack = 1'b0; mem_rdata = 16'h0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{16'h7800, 16'h1234, 1'b0, 4'b0010, 1'b1, 1'b0};
        vecs[1]  = '{16'h7400, 16'h1234, 1'b0, 4'b0111, 1'b0, 1'b0};
        vecs[2]  = '{16'h7200, 16'h1234, 1'b0, 4'b0011, 1'b1, 1'b0};
        vecs[3]  = '{16'h7100, 16'h1234, 1'b0, 4'b1000, 1'b0, 1'b0};
        vecs[4]  = '{16'h7080, 16'h1234, 1'b0, 4'b0100, 1'b1, 1'b0};
        vecs[5]  = '{16'h7040, 16'h1234, 1'b0, 4'b0101, 1'b1, 1'b0};
        vecs[6]  = '{16'h7020, 16'h1234, 1'b0, 4'b0110, 1'b1, 1'b0};
        vecs[7]  = '{16'h7010, 16'h7FFF, 1'b0, 4'b1001, 1'b0, 1'b1};
        vecs[8]  = '{16'h7008, 16'h7FFF, 1'b0, 4'b1010, 1'b0, 1'b0};
        vecs[9]  = '{16'h7008, 16'h8001, 1'b0, 4'b1010, 1'b0, 1'b1};
        vecs[10] = '{16'h7004, 16'h0001, 1'b0, 4'b1011, 1'b0, 1'b0};
        vecs[11] = '{16'h7002, 16'h0001, 1'b0, 4'b1100, 1'b0, 1'b1};
        vecs[12] = '{16'h7002, 16'h0001, 1'b1, 4'b1100, 1'b0, 1'b0};

        RST = 1'b1; ir_valid = 1'b0; ir = 16'h0; ac = 16'h0; E = 1'b0;
        mem_ack = 1'b0; mem_rdata = 16'h0;
        #12;
        chk("rst_mem_req", mem_req, 1'b0);
        chk("rst_mem_we", mem_we, 1'b0);
        chk("rst_mem_addr", mem_addr, 12'h0);
        chk("rst_ac_load", ac_load, 1'b0);
        chk("rst_skip", skip, 1'b0);
        chk("rst_halt", halt, 1'b0);
        chk("rst_illegal", illegal, 1'b0);
        chk("rst_aluop", ALUOP, 4'b1101);
        chk("rst_ir_ready", ir_ready, 1'b1);
        chk("rst_dr", dr, 16'h0);
        @(negedge CLK) RST = 1'b0;

        // Single-bit register-reference table
        for (int i = 0; i < 13; i++) begin
            ac = vecs[i].ac; E = vecs[i].e;
            issue(vecs[i].ir);
            @(negedge CLK);
            $display("vec %0d ir=%h ac=%h E=%b aluop=%b load=%b skip=%b", i, vecs[i].ir, ac, E, ALUOP, ac_load, skip);
            chk($sformatf("v%0d_aluop", i), ALUOP, vecs[i].aluop);
            chk($sformatf("v%0d_load", i), ac_load, vecs[i].load);
            chk($sformatf("v%0d_skip", i), skip, vecs[i].skp);
            chk($sformatf("v%0d_busy", i), ir_ready, 1'b0);
            @(negedge CLK);
            chk($sformatf("v%0d_done", i), ir_ready, 1'b1);
            chk($sformatf("v%0d_idle_op", i), ALUOP, 4'b1101);
        end

        // NOP: mask 0 never leaves IDLE
        issue(16'h7000);
        @(negedge CLK);
        $display("nop ir_ready=%b", ir_ready);
        chk("nop_ready", ir_ready, 1'b1);
        chk("nop_load", ac_load, 1'b0);

        // CLA|INC
        ac = 16'h1234;
        issue(16'h7820);
        @(negedge CLK);
        chk("clainc_c1_op", ALUOP, 4'b0010);
        chk("clainc_c1_load", ac_load, 1'b1);
        @(negedge CLK);
        chk("clainc_c2_op", ALUOP, 4'b0110);
        chk("clainc_c2_load", ac_load, 1'b1);
        chk("clainc_c2_ready", ir_ready, 1'b0);
        @(negedge CLK);
        $display("clainc done ir_ready=%b", ir_ready);
        chk("clainc_c3_ready", ir_ready, 1'b1);

        // ADD direct, ack on the third request cycle
        issue(16'h1050);
        for (int c = 0; c < 3; c++) begin
            @(negedge CLK);
            chk($sformatf("add_req%0d", c), mem_req, 1'b1);
            chk($sformatf("add_addr%0d", c), mem_addr, 12'h050);
            chk($sformatf("add_we%0d", c), mem_we, 1'b0);
            chk($sformatf("add_op%0d", c), ALUOP, 4'b1101);
        end
        ack_now(16'h00FF);
        @(negedge CLK);
        chk("add_exec_op", ALUOP, 4'b0001);
        chk("add_exec_load", ac_load, 1'b1);
        chk("add_dr", dr, 16'h00FF);
        chk("add_exec_req", mem_req, 1'b0);
        @(negedge CLK);
        $display("add done ALUOP=%b ir_ready=%b", ALUOP, ir_ready);
        chk("add_after_op", ALUOP, 4'b1101);
        chk("add_after_ready", ir_ready, 1'b1);

        // LDA indirect
        issue(16'hA010);
        @(negedge CLK);
        chk("ldai_addr1", mem_addr, 12'h010);
        chk("ldai_req1", mem_req, 1'b1);
        ack_now(16'h0123);
        @(negedge CLK);
        chk("ldai_addr2", mem_addr, 12'h123);
        chk("ldai_we2", mem_we, 1'b0);
        chk("ldai_op2", ALUOP, 4'b1101);
        ack_now(16'hBEEF);
        @(negedge CLK);
        chk("ldai_op", ALUOP, 4'b1101);
        chk("ldai_load", ac_load, 1'b1);
        chk("ldai_dr", dr, 16'hBEEF);
        @(negedge CLK);
        $display("ldai done dr=%h", dr);
        chk("ldai_ready", ir_ready, 1'b1);

        // Stray ack in IDLE must not touch dr
        mem_ack = 1'b1; mem_rdata = 16'h5555;
        @(posedge CLK);
        #1 mem_ack = 1'b0;
        @(negedge CLK);
        $display("stray ack dr=%h", dr);
        chk("stray_dr", dr, 16'hBEEF);
        chk("stray_ready", ir_ready, 1'b1);

        // STA direct
        ac = 16'hCAFE;
        issue(16'h3055);
        @(negedge CLK);
        chk("sta_we", mem_we, 1'b1);
        chk("sta_req", mem_req, 1'b1);
        chk("sta_addr", mem_addr, 12'h055);
        chk("sta_wdata", mem_wdata, 16'hCAFE);
        chk("sta_load", ac_load, 1'b0);
        ack_now(16'h0);
        @(negedge CLK);
        $display("sta done mem_req=%b", mem_req);
        chk("sta_done_req", mem_req, 1'b0);
        chk("sta_done_ready", ir_ready, 1'b1);

        // SPA|SZA with ac=0: both skip
        ac = 16'h0000;
        issue(16'h7014);
        @(negedge CLK);
        chk("sk0_c1_op", ALUOP, 4'b1001);
        chk("sk0_c1_skip", skip, 1'b1);
        chk("sk0_c1_load", ac_load, 1'b0);
        @(negedge CLK);
        chk("sk0_c2_op", ALUOP, 4'b1011);
        chk("sk0_c2_skip", skip, 1'b1);
        chk("sk0_c2_load", ac_load, 1'b0);
        @(negedge CLK);
        $display("spa|sza ac=0000 done skip=%b", skip);
        chk("sk0_end_skip", skip, 1'b0);

        // SPA|SZA with ac=0x8000: no skip
        ac = 16'h8000;
        issue(16'h7014);
        @(negedge CLK);
        chk("sk8_c1_skip", skip, 1'b0);
        @(negedge CLK);
        chk("sk8_c2_skip", skip, 1'b0);
        chk("sk8_c2_op", ALUOP, 4'b1011);
        @(negedge CLK);
        $display("spa|sza ac=8000 done ir_ready=%b", ir_ready);
        chk("sk8_ready", ir_ready, 1'b1);

        // Reset while OPERAND request is outstanding
        issue(16'h0020);
        @(negedge CLK);
        chk("rop_req_before", mem_req, 1'b1);
        #2 RST = 1'b1;
        #1;
        chk("rop_req_async", mem_req, 1'b0);
        @(negedge CLK) RST = 1'b0;
        #1;
        $display("reset mid-operand ir_ready=%b ALUOP=%b", ir_ready, ALUOP);
        chk("rop_ready", ir_ready, 1'b1);
        chk("rop_aluop", ALUOP, 4'b1101);

        // Illegal opcode
        issue(16'h4000);
        @(negedge CLK);
        chk("ill_pulse", illegal, 1'b1);
        chk("ill_req", mem_req, 1'b0);
        chk("ill_ready", ir_ready, 1'b1);
        @(negedge CLK);
        $display("illegal done illegal=%b", illegal);
        chk("ill_clear", illegal, 1'b0);

        // HLT followed by further valid instructions
        issue(16'h7001);
        @(negedge CLK);
        chk("hlt_load", ac_load, 1'b0);
        @(negedge CLK);
        chk("hlt_halt", halt, 1'b1);
        chk("hlt_ready", ir_ready, 1'b0);
        ir = 16'h1050; ir_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge CLK);
            chk($sformatf("hlt_stay%0d", c), halt, 1'b1);
            chk($sformatf("hlt_noreq%0d", c), mem_req, 1'b0);
            chk($sformatf("hlt_nordy%0d", c), ir_ready, 1'b0);
        end
        ir_valid = 1'b0;
        RST = 1'b1;
        #1;
        $display("halt exit via reset halt=%b", halt);
        chk("hlt_rst_halt", halt, 1'b0);
        chk("hlt_rst_ready", ir_ready, 1'b1);
        @(negedge CLK) RST = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
